sprite_loader: RTL

SPRITE_LOADER -- requirements
Module: sprite_loader

---
 rtl/sprite_loader_if.sv | 31 +++
 rtl/sprite_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sprite_loader_if.sv
// Sprite loader bus bundle: RLE byte stream in, sprite-RAM write port out.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready handshake on the stream; the RAM port has none.
interface sprite_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [17:0] write_address;
  logic [4:0]  data_in;

  // Stream source / RAM sink side (e.g. the environment feeding the loader)
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  we,
    input  write_address,
    input  data_in
  );

  // Loader side
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output we,
    output write_address,
    output data_in
  );
endinterface

// File: rtl/sprite_loader.sv
// Expands an RLE byte stream ({run-1[7:5], palette[4:0]}) into sprite-RAM writes.
// Latency: one cycle from each EXPAND cycle to its registered write; done one cycle after FINISH.
// Backpressure: in_ready only in FETCH; the RAM write port is never stalled.
module sprite_loader #(
  parameter logic [17:0] RESV_LO = 18'd1704,
  parameter logic [17:0] RESV_HI = 18'd1706
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [17:0] base_addr,
  input  logic [17:0] length,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  sprite_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXPAND = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [17:0] addr_cnt;
  logic [17:0] remaining;
  logic [3:0]  run;
  logic [4:0]  palette;

  logic        we_q;
  logic [17:0] wr_addr_q;
  logic [4:0]  wr_dat_q;
  logic        done_q;
  logic        overrun_q;

  logic        accept;
  logic        handshake;
  logic        reserved;
  logic [17:0] rem_dec;
  logic [3:0]  run_dec;

  // start is only honoured while idle; the stream is only consumed in FETCH
  assign accept    = (state == IDLE) && start;
  assign handshake = (state == FETCH) && bus.in_valid;
  assign rem_dec   = remaining - 18'd1;
  assign run_dec   = run - 4'd1;
  // palette slots that must never be overwritten by a sprite load
  assign reserved  = (addr_cnt >= RESV_LO) && (addr_cnt <= RESV_HI);

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and combinational status outputs
  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    bus.in_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length == 18'd0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        busy         = 1'b1;
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        busy = 1'b1;
        // running out of pixels ends the load even mid-run
        if (rem_dec == 18'd0) begin
          state_nxt = FINISH;
        end else if (run_dec == 4'd0) begin
          state_nxt = FETCH;
        end
      end
      FINISH: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // counters, latched run/palette and registered write port
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_cnt  <= 18'd0;
      remaining <= 18'd0;
      run       <= 4'd0;
      palette   <= 5'd0;
      we_q      <= 1'b0;
      wr_addr_q <= 18'd0;
      wr_dat_q  <= 5'd0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      we_q   <= (state == EXPAND) && !reserved;
      done_q <= (state == FINISH);

      if (accept) begin
        addr_cnt  <= base_addr;
        remaining <= length;
        overrun_q <= 1'b0;
      end

      if (handshake) begin
        palette <= bus.in_data[4:0];
        run     <= {1'b0, bus.in_data[7:5]} + 4'd1;
      end

      if (state == EXPAND) begin
        // address is presented even for suppressed reserved pixels
        wr_addr_q <= addr_cnt;
        wr_dat_q  <= palette;
        addr_cnt  <= addr_cnt + 18'd1;
        remaining <= rem_dec;
        run       <= run_dec;
        // stream described more pixels than the load length allows
        if ((rem_dec == 18'd0) && (run_dec != 4'd0)) begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign bus.we            = we_q;
  assign bus.write_address = wr_addr_q;
  assign bus.data_in       = wr_dat_q;
  assign done              = done_q;
  assign overrun           = overrun_q;

endmodule
